fwd_hazard_unit: RTL

//  Parametrised operand-forwarding and load-use hazard unit for the 5-stage pipeline.
//  - Keeps its own shadow copy of the destination tags for EX, MEM and WB, fed from decode.
//  - Produces per-source forwarding selects for the operand muxes in front of EX.
//  - Detects load-use hazards; asserts stall (hold PC and IF/ID) and bubble (zero ID/EX control).
//  - Counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit_pkg.sv | 32 +++
 rtl/fwd_hazard_unit_src_sel.sv | 58 +++++
 rtl/fwd_hazard_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

  // Tag storage is sized for the widest supported register address; narrower
  // configurations zero-extend, and synthesis trims the constant upper bits.
  localparam int unsigned MAX_REG_ADDR_W = 8;
  localparam int unsigned FWD_SEL_W      = 3;

  localparam logic [FWD_SEL_W-1:0] FWD_RF   = 3'b000;
  localparam logic [FWD_SEL_W-1:0] FWD_EX   = 3'b001;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM  = 3'b010;
  localparam logic [FWD_SEL_W-1:0] FWD_WB   = 3'b011;
  localparam logic [FWD_SEL_W-1:0] FWD_FLAG = 3'b100;

  typedef logic [MAX_REG_ADDR_W-1:0] reg_addr_t;

  // Destination tag carried alongside each in-flight instruction.
  typedef struct packed {
    reg_addr_t dst;
    logic      wb;
    logic      load;
  } stage_tag_t;

  // A stage supplies a source when it writes back the same register,
  // unless that register is the hardwired zero.
  function automatic logic tag_match(input reg_addr_t dst, input logic wb,
                                     input reg_addr_t src, input logic used,
                                     input logic zero_reg);
    return used & wb & (dst == src) & ~(zero_reg & (src == '0));
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// Per-source forwarding priority compare (EX > MEM > WB > RF) and load-hit flag.
module fwd_hazard_unit_src_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                 id_valid_i,
  input  reg_addr_t            src_i,
  input  logic                 used_i,
  input  logic                 use_flag_i,
  input  stage_tag_t           ex_tag_i,
  input  stage_tag_t           mem_tag_i,
  input  stage_tag_t           wb_tag_i,
  output logic [FWD_SEL_W-1:0] fwd_sel_c_o,
  output logic                 load_hit_c_o
);

  localparam logic LOAD_FROM_WB = (LOAD_STALL == 2);
  localparam logic ZERO_CHK     = (ZERO_REG != 0);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_wb_load;

  // Loads retiring from WB never cause a stall, so that flag is not consulted.
  assign unused_wb_load = wb_tag_i.load;

  // Stage-by-stage tag compares.
  always_comb begin
    hit_ex  = tag_match(ex_tag_i.dst,  ex_tag_i.wb,  src_i, used_i, ZERO_CHK);
    hit_mem = tag_match(mem_tag_i.dst, mem_tag_i.wb, src_i, used_i, ZERO_CHK);
    hit_wb  = tag_match(wb_tag_i.dst,  wb_tag_i.wb,  src_i, used_i, ZERO_CHK);
  end

  // Youngest matching stage wins; load data is not ready in MEM when loads take two cycles.
  always_comb begin
    fwd_sel_c_o = FWD_RF;
    if (!id_valid_i) begin
      fwd_sel_c_o = FWD_RF;
    end else if (use_flag_i) begin
      fwd_sel_c_o = FWD_FLAG;
    end else if (hit_ex) begin
      fwd_sel_c_o = FWD_EX;
    end else if (hit_mem && !(LOAD_FROM_WB && mem_tag_i.load)) begin
      fwd_sel_c_o = FWD_MEM;
    end else if (hit_wb) begin
      fwd_sel_c_o = FWD_WB;
    end
  end

  // This source depends on a load whose data is not yet forwardable.
  always_comb begin
    load_hit_c_o = (hit_ex & ex_tag_i.load) | (LOAD_FROM_WB & hit_mem & mem_tag_i.load);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: shadow EX/MEM/WB tag pipeline,
// per-source forwarding selects, stall/bubble generation and a stall counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_wb,
  input  logic                          id_is_load,
  input  logic                          id_use_flag,
  input  logic                          flush,
  output logic [NUM_SRC*FWD_SEL_W-1:0]  fwd_sel,
  output logic                          stall,
  output logic                          bubble_ex,
  output logic [CNT_W-1:0]              stall_cycles
);

  stage_tag_t ex_q,  ex_d;
  stage_tag_t mem_q, mem_d;
  stage_tag_t wb_q,  wb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] load_hit;
  logic               sel_valid;
  logic               hazard_c;

  // Selects are held at zero while the unit is in reset.
  assign sel_valid = id_valid & rst_n;

  // One compare slice per source operand; only src0 can take the flag path.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_hazard_unit_src_sel #(
      .LOAD_STALL (LOAD_STALL),
      .ZERO_REG   (ZERO_REG)
    ) u_src (
      .id_valid_i   (sel_valid),
      .src_i        (MAX_REG_ADDR_W'(id_src_addr[g*REG_ADDR_W +: REG_ADDR_W])),
      .used_i       (id_src_used[g]),
      .use_flag_i   ((g == 0) ? id_use_flag : 1'b0),
      .ex_tag_i     (ex_q),
      .mem_tag_i    (mem_q),
      .wb_tag_i     (wb_q),
      .fwd_sel_c_o  (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W]),
      .load_hit_c_o (load_hit[g])
    );
  end

  // Load-use hazard; a flush squashes the ID instruction so it cannot stall.
  always_comb begin
    hazard_c = sel_valid & ~flush & (|load_hit);
  end

  assign stall        = hazard_c;
  assign bubble_ex    = hazard_c;
  assign stall_cycles = cnt_q;

  // Next tag pipeline and saturating stall counter.
  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    if (flush) begin
      mem_d = '0;
    end else if (id_valid && !hazard_c) begin
      ex_d.dst  = MAX_REG_ADDR_W'(id_dst_addr);
      ex_d.wb   = id_wb;
      ex_d.load = id_is_load;
    end
    if (hazard_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
